// File: rtl/memory_ctrl.sv
// rtl/memory_ctrl.sv - RISC-V load/store unit between execute stage and synchronous SRAM (optional MEMORY_CTRL_TIMEOUT_EN ack timeout)
module memory_ctrl #(
    parameter int random_errors = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  instr,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] op3,
    input  logic        enable,
    output logic [31:0] result,
    output logic        result_valid,
    output logic [31:0] address,
    output logic        read_enable,
    input  logic [31:0] read_data,
    input  logic        read_ack,
    output logic        write_enable,
    output logic [3:0]  write_byte_enable,
    output logic [31:0] write_data,
    input  logic        write_ack
);

    // Opcode encoding of the instr bus; every other code is not a memory op.
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam bit ERR_EN = (random_errors != 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD      = 2'd1,
        S_RD_DATA = 2'd2,
        S_WR      = 2'd3
    } state_t;

    state_t      state_q;
    logic [3:0]  instr_q;
    logic [1:0]  lane_q;
    logic [31:0] result_q;
    logic        result_valid_q;
    logic [31:0] address_q;
    logic        read_enable_q;
    logic        write_enable_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [1:0]  err_cnt_q;
`ifdef MEMORY_CTRL_TIMEOUT_EN
    logic [3:0]  wait_cnt_q;
`endif

    logic [31:0] ea_d;
    logic [1:0]  lane_d;
    logic        is_load_d;
    logic        is_store_d;
    logic        misaligned_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  ld_byte_d;
    logic [15:0] ld_half_d;
    logic [31:0] load_d;
    logic [31:0] load_final_d;

    // Decode the incoming request: effective address, op class, alignment and store lanes.
    always_comb begin
        ea_d         = op1 + op2;
        lane_d       = ea_d[1:0];
        is_load_d    = 1'b0;
        is_store_d   = 1'b0;
        misaligned_d = 1'b0;
        be_d         = 4'b0000;
        wdata_d      = 32'd0;
        case (instr)
            OP_LB, OP_LBU: begin
                is_load_d = 1'b1;
            end
            OP_LH, OP_LHU: begin
                is_load_d    = 1'b1;
                misaligned_d = lane_d[0];
            end
            OP_LW: begin
                is_load_d    = 1'b1;
                misaligned_d = (lane_d != 2'b00);
            end
            OP_SB: begin
                is_store_d = 1'b1;
                be_d       = 4'b0001 << lane_d;
                wdata_d    = {4{op3[7:0]}};
            end
            OP_SH: begin
                is_store_d   = 1'b1;
                misaligned_d = lane_d[0];
                be_d         = lane_d[1] ? 4'b1100 : 4'b0011;
                wdata_d      = {2{op3[15:0]}};
            end
            OP_SW: begin
                is_store_d   = 1'b1;
                misaligned_d = (lane_d != 2'b00);
                be_d         = 4'b1111;
                wdata_d      = op3;
            end
            default: begin
                is_load_d  = 1'b0;
                is_store_d = 1'b0;
            end
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        ld_byte_d = read_data[{lane_q, 3'b000} +: 8];
        ld_half_d = lane_q[1] ? read_data[31:16] : read_data[15:0];
        case (instr_q)
            OP_LB:   load_d = {{24{ld_byte_d[7]}}, ld_byte_d};
            OP_LBU:  load_d = {24'd0, ld_byte_d};
            OP_LH:   load_d = {{16{ld_half_d[15]}}, ld_half_d};
            OP_LHU:  load_d = {16'd0, ld_half_d};
            default: load_d = read_data;
        endcase
        load_final_d = load_d;
        if (ERR_EN && (err_cnt_q == 2'd3)) begin
            load_final_d[0] = ~load_d[0];
        end
    end

    // Request sequencer with registered memory-side and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            instr_q        <= 4'd0;
            lane_q         <= 2'd0;
            result_q       <= 32'd0;
            result_valid_q <= 1'b0;
            address_q      <= 32'd0;
            read_enable_q  <= 1'b0;
            write_enable_q <= 1'b0;
            be_q           <= 4'd0;
            wdata_q        <= 32'd0;
            err_cnt_q      <= 2'd0;
`ifdef MEMORY_CTRL_TIMEOUT_EN
            wait_cnt_q     <= 4'd0;
`endif
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable && (is_load_d || is_store_d)) begin
                        instr_q <= instr;
                        lane_q  <= lane_d;
`ifdef MEMORY_CTRL_TIMEOUT_EN
                        wait_cnt_q <= 4'd0;
`endif
                        if (misaligned_d) begin
                            // Misaligned access never reaches memory; complete at once with zero.
                            result_q       <= 32'd0;
                            result_valid_q <= 1'b1;
                        end else if (is_load_d) begin
                            address_q     <= ea_d;
                            read_enable_q <= 1'b1;
                            state_q       <= S_RD;
                        end else begin
                            address_q      <= ea_d;
                            write_enable_q <= 1'b1;
                            be_q           <= be_d;
                            wdata_q        <= wdata_d;
                            state_q        <= S_WR;
                        end
                    end
                end
                S_RD: begin
                    if (read_ack) begin
                        read_enable_q <= 1'b0;
                        state_q       <= S_RD_DATA;
                    end
`ifdef MEMORY_CTRL_TIMEOUT_EN
                    else if (wait_cnt_q == 4'hF) begin
                        read_enable_q  <= 1'b0;
                        result_q       <= 32'hDEAD_BEEF;
                        result_valid_q <= 1'b1;
                        state_q        <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
`endif
                end
                S_RD_DATA: begin
                    // Memory word is valid the cycle after the accepted read.
                    result_q       <= load_final_d;
                    result_valid_q <= 1'b1;
                    err_cnt_q      <= err_cnt_q + 2'd1;
                    state_q        <= S_IDLE;
                end
                S_WR: begin
                    if (write_ack) begin
                        write_enable_q <= 1'b0;
                        be_q           <= 4'd0;
                        result_q       <= 32'd0;
                        result_valid_q <= 1'b1;
                        state_q        <= S_IDLE;
                    end
`ifdef MEMORY_CTRL_TIMEOUT_EN
                    else if (wait_cnt_q == 4'hF) begin
                        write_enable_q <= 1'b0;
                        be_q           <= 4'd0;
                        result_q       <= 32'hDEAD_BEEF;
                        result_valid_q <= 1'b1;
                        state_q        <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign result            = result_q;
    assign result_valid      = result_valid_q;
    assign address           = address_q;
    assign read_enable       = read_enable_q;
    assign write_enable      = write_enable_q;
    assign write_byte_enable = be_q;
    assign write_data        = wdata_q;

endmodule

// File: tb/tb_memory_ctrl.sv
// tb/tb_memory_ctrl.sv - randomized self-checking bench for memory_ctrl against a byte-level reference model
module tb_memory_ctrl;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  instr;
    logic [31:0] op1, op2, op3;
    logic        enable;
    logic [31:0] result;
    logic        result_valid;
    logic [31:0] address;
    logic        read_enable;
    logic [31:0] read_data;
    logic        read_ack;
    logic        write_enable;
    logic [3:0]  write_byte_enable;
    logic [31:0] write_data;
    logic        write_ack;

    always #5 clk = ~clk;

    memory_ctrl #(.random_errors(0)) dut (
        .clk(clk), .rst(rst), .instr(instr), .op1(op1), .op2(op2), .op3(op3),
        .enable(enable), .result(result), .result_valid(result_valid),
        .address(address), .read_enable(read_enable), .read_data(read_data),
        .read_ack(read_ack), .write_enable(write_enable),
        .write_byte_enable(write_byte_enable), .write_data(write_data),
        .write_ack(write_ack)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed memory. SRAM stand-in: word array driven by the DUT lanes.
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] sram    [0:255];

    int          ack_mode = 0;   // 0: ack at once, 1: random ack, 2: hold off
    int          rd_seen  = 0;
    int          wr_seen  = 0;
    logic [31:0] last_raddr, last_waddr, last_wdata;
    logic [3:0]  last_be;

    initial begin
        logic        rd_take, wr_take, ra, wa;
        logic [31:0] rd_addr, wr_addr, wr_data;
        logic [3:0]  wr_be;
        read_ack  = 1'b0;
        write_ack = 1'b0;
        read_data = 32'd0;
        forever begin
            @(negedge clk);
            ra = (ack_mode == 0) || ((ack_mode == 1) && ($urandom_range(0, 2) == 0));
            wa = (ack_mode == 0) || ((ack_mode == 1) && ($urandom_range(0, 2) == 0));
            read_ack  = read_enable && ra;
            write_ack = write_enable && wa;
            if (read_enable === 1'b1) rd_seen++;
            if (write_enable === 1'b1) wr_seen++;
            rd_take = read_enable && read_ack && !rst;
            wr_take = write_enable && write_ack && !rst;
            rd_addr = address;
            wr_addr = address;
            wr_data = write_data;
            wr_be   = write_byte_enable;
            @(posedge clk);
            #1;
            if (rd_take) begin
                last_raddr = rd_addr;
                read_data  = sram[rd_addr[9:2]];
            end
            if (wr_take) begin
                last_waddr = wr_addr;
                last_wdata = wr_data;
                last_be    = wr_be;
                for (int i = 0; i < 4; i++)
                    if (wr_be[i]) sram[wr_addr[9:2]][8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] ea);
        logic [9:0]  a;
        logic [7:0]  bt;
        logic [15:0] h;
        logic [31:0] w;
        a  = ea[9:0];
        bt = ref_mem[a];
        h  = {ref_mem[a + 10'd1], ref_mem[a]};
        w  = {ref_mem[a + 10'd3], ref_mem[a + 10'd2], ref_mem[a + 10'd1], ref_mem[a]};
        case (op)
            OP_LB:   return {{24{bt[7]}}, bt};
            OP_LBU:  return {24'd0, bt};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, output logic [31:0] res, output logic [3:0] be_o);
        logic [31:0] ea, exp_res, exp_wd;
        logic [1:0]  l;
        logic        ld, st, mis;
        logic [3:0]  exp_be;
        int          rd0, wr0, cyc;
        bit          got;
        ea  = a + b;
        l   = ea[1:0];
        ld  = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
        st  = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        mis = (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && l[0]) ||
              (((op == OP_LW) || (op == OP_SW)) && (l != 2'b00));
        exp_res = (ld && !mis) ? model_load(op, ea) : 32'd0;
        exp_be  = (op == OP_SB) ? (4'b0001 << l) : (op == OP_SH) ? (l[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        exp_wd  = (op == OP_SB) ? {4{d[7:0]}} : (op == OP_SH) ? {2{d[15:0]}} : d;
        rd0 = rd_seen;
        wr0 = wr_seen;
        last_be = 4'd0;
        instr = op; op1 = a; op2 = b; op3 = d; enable = 1'b1;
        cyc = 0;
        got = 0;
        while (!got && cyc < 200) begin
            @(posedge clk);
            cyc++;
            if (cyc == 1) begin
                #1;
                enable = 1'b0;
                instr  = OP_NOP;
            end
            @(negedge clk);
            if (result_valid === 1'b1) got = 1;
        end
        check("done", {31'd0, got}, 32'd1);
        res  = result;
        be_o = last_be;
        if (got) begin
            check("result", result, exp_res);
            if (ack_mode == 0) check("latency", cyc, mis ? 1 : (ld ? 3 : 2));
            if (mis) begin
                check("mis_no_req", rd_seen - rd0 + wr_seen - wr0, 0);
            end else if (st) begin
                check("wr_be", {28'd0, last_be}, {28'd0, exp_be});
                check("wr_addr", last_waddr, ea);
                check("wr_data", last_wdata, exp_wd);
                for (int i = 0; i < 4; i++)
                    if (exp_be[i] && (i >= l)) ref_mem[ea[9:0] + 10'(i - l)] = d[8*(i-l) +: 8];
            end else begin
                check("rd_addr", last_raddr, ea);
            end
        end
        @(negedge clk);
        check("pulse", {31'd0, result_valid}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=stall exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, ea, b;
        logic [3:0]  be;
        logic [3:0]  op;
        int          rd0, wr0, cyc, seen;
        bit          got;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++)
            sram[i] = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};

        rst = 1'b1; instr = OP_NOP; op1 = 0; op2 = 0; op3 = 0; enable = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("rst_outs_zero", {31'd0, |{result, result_valid, address, read_enable,
                                             write_enable, write_byte_enable, write_data}}, 32'd0);
        end
        check("rst_result", result, 32'd0);
        check("rst_addr", address, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed scenarios
        do_op(OP_SW, 32'h100, 32'h0, 32'hDEADBEEF, r, be);
        check("sw_be", {28'd0, be}, 32'hF);
        do_op(OP_LW, 32'h100, 32'h0, 32'h0, r, be);
        check("lw_100", r, 32'hDEADBEEF);
        do_op(OP_SB, 32'h100, 32'h1, 32'hAA, r, be);
        check("sb_be", {28'd0, be}, 32'h2);
        do_op(OP_LBU, 32'h101, 32'h0, 32'h0, r, be);
        check("lbu_101", r, 32'h000000AA);
        do_op(OP_LB, 32'h101, 32'h0, 32'h0, r, be);
        check("lb_101", r, 32'hFFFFFFAA);
        do_op(OP_SH, 32'h102, 32'h0, 32'h8001, r, be);
        check("sh_be", {28'd0, be}, 32'hC);
        do_op(OP_LH, 32'h102, 32'h0, 32'h0, r, be);
        check("lh_102", r, 32'hFFFF8001);
        do_op(OP_LHU, 32'h102, 32'h0, 32'h0, r, be);
        check("lhu_102", r, 32'h00008001);
        do_op(OP_LW, 32'h103, 32'h0, 32'h0, r, be);
        check("lw_mis", r, 32'd0);
        do_op(OP_SW, 32'h0FF, 32'h1, 32'h12345678, r, be);
        check("lw_after_sw", model_load(OP_LW, 32'h100), 32'h12345678);
        do_op(OP_LW, 32'h100, 32'h0, 32'h0, r, be);
        check("lw_100b", r, 32'h12345678);

        // Non-memory opcode with enable must be ignored
        rd0 = rd_seen; wr0 = wr_seen; seen = 0;
        instr = 4'hF; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0; instr = OP_NOP;
        repeat (5) begin
            @(negedge clk);
            if (result_valid === 1'b1) seen++;
        end
        check("nop_ignored", seen + rd_seen - rd0 + wr_seen - wr0, 0);

        // Enable held with a store while a load waits for its ack
        ack_mode = 2;
        wr0 = wr_seen;
        instr = OP_LW; op1 = 32'h100; op2 = 0; enable = 1'b1;
        @(posedge clk); #1;
        instr = OP_SW; op1 = 32'h200; op3 = 32'hCAFEF00D;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rd_held", {31'd0, read_enable}, 32'd1);
        @(posedge clk); #1;
        enable = 1'b0; instr = OP_NOP;
        ack_mode = 0;
        got = 0; cyc = 0;
        while (!got && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (result_valid === 1'b1) got = 1;
        end
        check("busy_done", {31'd0, got}, 32'd1);
        check("busy_result", result, model_load(OP_LW, 32'h100));
        check("busy_no_wr", wr_seen - wr0, 0);
        repeat (2) @(posedge clk);

        // Reset in RD_DATA aborts without a result
        @(posedge clk); #1;
        instr = OP_LW; op1 = 32'h100; op2 = 0; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0; instr = OP_NOP;
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        @(negedge clk);
        if (result_valid === 1'b1) seen++;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (result_valid === 1'b1) seen++;
        end
        check("rst_abort", seen, 0);
        @(posedge clk); #1;
        do_op(OP_LW, 32'h100, 32'h0, 32'h0, r, be);
        check("lw_after_rst", r, 32'h12345678);

        // Randomized traffic
        for (int n = 0; n < 120; n++) begin
            ack_mode = $urandom_range(0, 1);
            op = 4'($urandom_range(1, 8));
            ea = {22'd0, 10'($urandom)};
            if ($urandom_range(0, 3) != 0) begin
                if (op == OP_LW || op == OP_SW) ea[1:0] = 2'b00;
                if (op == OP_LH || op == OP_LHU || op == OP_SH) ea[0] = 1'b0;
            end
            b = $urandom;
            do_op(op, ea - b, b, $urandom, r, be);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
